rc5_encoder: RTL and testbench
==============================

# rc5_encoder

Fully pipelined RC5-32/12/16 block encryptor with a fixed, pre-expanded 128-bit all-zero key. It takes a 64-bit plaintext block every clock and produces the matching 64-bit ciphertext 13 clock edges later. There is no handshake: the output always reflects the input sampled 13 edges earlier. The block sits between the message source and downstream consumers in the RC5 datapath.

## Interface
- No parameters. Word size, round count and key are fixed: w=32, r=12, b=16.
- clk  input  1   single clock; all state changes on the rising edge.
- rst  input  1   asynchronous, active-high reset.
- d_in  input  64  plaintext block, sampled every rising edge.
  - d_in[63:32] is word A; d_in[31:0] is word B.
- d_out  output  64  ciphertext block, registered: d_out = {A12, B12}.
- d_valid  output  1  present only with RC5_VALID_EN (see Configuration).

## Operation
- Expanded key table S[0..25]: 26 × 32-bit constants.
  - Derived with the standard RC5 key schedule: P32=32'hB7E15163, Q32=32'h9E3779B9, 128-bit all-zero key, 3·26 mixing iterations.
  - Held as constants; no key-expansion hardware.
- Stage 0 (pre-whitening), registered:
  - A0 = d_in[63:32] + S[0]
  - B0 = d_in[31:0] + S[1]
- Stages i = 1..12, one round per stage, registered:
  - Ai = ((A(i-1) ^ B(i-1)) <<< B(i-1)[4:0]) + S[2i]
  - Bi = ((B(i-1) ^ Ai) <<< Ai[4:0]) + S[2i+1]
  - Bi uses the new Ai computed in the same stage (combinational chain).
- Arithmetic rules:
  - Additions are modulo 2^32; carries are discarded.
  - Rotates are left circular by the low 5 bits only.
  - A rotate amount of 0 passes the word through unchanged.
- d_out is driven directly by the stage-12 registers.
- Pipeline stages are independent: a new block may enter every cycle, and consecutive different blocks never corrupt each other.

## Timing
- Reset (rst=1, asynchronous): all stage registers, d_out and d_valid clear to 0 immediately and stay 0 while rst is high.
- First sample: the first rising edge with rst=0 samples d_in into stage 0.
- Latency:
  - d_in sampled at edge n appears on d_out after edge n+12.
  - Stable for any d_in held ≥ 13 cycles.
  - Throughput is 1 block per cycle.
- Output after reset: until 13 edges have passed, d_out shows ciphertext of whatever occupies the pipeline. Bubbles are all-zero registers that are still processed as data, not plaintext 0. d_out holds no meaningful value in this window.
- Reset mid-operation: all in-flight blocks are discarded. Output resumes 13 edges after deassertion.
- Input change while blocks are in flight: each block is encrypted independently. No stall and no flush.

## Configuration
- RC5_VALID_EN defined:
  - Adds output d_valid and a 13-bit shift register, cleared by rst, with 1 shifted in each cycle.
  - d_valid = 1 exactly when d_out holds a block that was sampled after the last reset deassertion.
  - d_valid first goes high after the 13th edge following deassertion.
- RC5_VALID_EN undefined: no d_valid port and no shift register. Data path is identical.

## Structure
- Package rc5_pkg holds:
  - word typedef (logic [31:0]);
  - constants W=32, R=12, T=26;
  - P32, Q32;
  - the S[0:25] constant array.
- Sub-module rc5_round:
  - Purely combinational.
  - Inputs: a, b, s_even, s_odd. Outputs: a_next, b_next.
  - Instantiated 12 times by a generate loop, with stage registers in the top module.
- Top module: rc5_encoder.

## Test plan
- Reset behaviour: assert rst mid-stream → d_out = 64'h0 immediately (asynchronously); d_valid = 0.
- Published vector: d_in = 64'h0000000000000000, held 13+ cycles → d_out = 64'hEEDBA521_6D8F4B15.
  - This is the published zero-key vector 21A5DBEE 154B8F6D with words read little-endian.
- Latency: apply a block on the cycle after reset release → d_out changes exactly after edge 13; d_valid rises on the same edge.
- Streaming: 200 random d_in, one per cycle, no gaps → each d_out equals a software RC5-32/12/16 model (zero key) result for the input 13 edges earlier.
- Rotate corner cases: inputs forcing rotate amounts of 0 and 31 (e.g. d_in = 64'hFFFFFFFF_FFFFFFFF, 64'h80000000_00000001) → match the model bit-exactly.
- Reset mid-stream: assert rst for 1 cycle during streaming → d_out = 0; first new ciphertext appears 13 edges after deassertion, matching the model.

Source files
------------

// File: rtl/rc5_pkg.sv
// -----------------------------------------------------------------------------
// rc5_pkg
// Shared types and constants for the RC5-32/12/16 encryptor (all-zero key).
//   word       : 32-bit RC5 word
//   W, R, T    : word size, round count, expanded-table size
//   P32, Q32   : RC5 magic constants
//   S          : expanded key table S[0..25], folded to constants at elaboration
//   rotl       : left circular rotate by the low 5 bits of the amount
// -----------------------------------------------------------------------------
package rc5_pkg;

   localparam int W = 32;
   localparam int R = 12;
   localparam int T = 2 * R + 2;

   typedef logic [W-1:0] word;
   typedef logic [0:T-1][W-1:0] s_table_t;

   localparam word P32 = 32'hB7E1_5163;
   localparam word Q32 = 32'h9E37_79B9;

   // Doubling the word makes a zero amount fall out naturally (upper half = x).
   function automatic word rotl(input word x, input logic [4:0] n);
      logic [2*W-1:0] t;
      t = {x, x} << n;
      return t[2*W-1:W];
   endfunction

   // Standard RC5 key schedule with a 16-byte all-zero key (c = 4 words).
   // Only ever evaluated as a constant, so it produces no hardware.
   function automatic s_table_t expand_key();
      s_table_t s;
      word      l [0:3];
      word      a;
      word      b;
      word      sum;
      int       i;
      int       j;
      for (int k = 0; k < 4; k++) l[k] = '0;
      s[0] = P32;
      for (int k = 1; k < T; k++) s[k] = s[k-1] + Q32;
      a = '0;
      b = '0;
      i = 0;
      j = 0;
      for (int k = 0; k < 3 * T; k++) begin
         s[i] = rotl(s[i] + a + b, 5'd3);
         a    = s[i];
         sum  = a + b;
         l[j] = rotl(l[j] + sum, sum[4:0]);
         b    = l[j];
         i    = (i + 1) % T;
         j    = (j + 1) % 4;
      end
      return s;
   endfunction

   localparam s_table_t S = expand_key();

endpackage

// File: rtl/rc5_round.sv
// -----------------------------------------------------------------------------
// rc5_round
// One combinational RC5 encryption round.
//   a, b     : words entering the round
//   s_even   : S[2i]
//   s_odd    : S[2i+1]
//   a_next   : ((a ^ b) <<< b) + s_even
//   b_next   : ((b ^ a_next) <<< a_next) + s_odd
// -----------------------------------------------------------------------------
module rc5_round
   import rc5_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] s_even,
   input  logic [31:0] s_odd,
   output logic [31:0] a_next,
   output logic [31:0] b_next
);

   // b_next depends on the freshly computed a_next within the same round.
   assign a_next = rotl(a ^ b, b[4:0]) + s_even;
   assign b_next = rotl(b ^ a_next, a_next[4:0]) + s_odd;

endmodule

// File: rtl/rc5_encoder.sv
// -----------------------------------------------------------------------------
// rc5_encoder
// Fully pipelined RC5-32/12/16 encryptor, fixed all-zero key. One block per
// clock, ciphertext appears 13 rising edges after the plaintext is sampled.
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset, clears every stage register
//   d_in    : plaintext {A, B}, sampled every edge
//   d_out   : ciphertext {A12, B12}, straight from the last stage register
//   d_valid : (only with `define RC5_VALID_EN) high when d_out carries a block
//             sampled after the most recent reset release
// -----------------------------------------------------------------------------
module rc5_encoder
   import rc5_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] d_in,
`ifdef RC5_VALID_EN
   output logic        d_valid,
`endif
   output logic [63:0] d_out
);

   // Index 0 is the pre-whitening stage, 1..R are the round stages.
   word a_q [0:R];
   word b_q [0:R];
   word a_d [0:R];
   word b_d [0:R];
   word ra  [1:R];
   word rb  [1:R];

   for (genvar i = 1; i <= R; i++) begin : g_round
      rc5_round u_round (
         .a      (a_q[i-1]),
         .b      (b_q[i-1]),
         .s_even (S[2*i]),
         .s_odd  (S[2*i+1]),
         .a_next (ra[i]),
         .b_next (rb[i])
      );
   end

   always_comb begin
      a_d[0] = d_in[63:32] + S[0];
      b_d[0] = d_in[31:0]  + S[1];
      for (int i = 1; i <= R; i++) begin
         a_d[i] = ra[i];
         b_d[i] = rb[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i <= R; i++) begin
            a_q[i] <= '0;
            b_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i <= R; i++) begin
            a_q[i] <= a_d[i];
            b_q[i] <= b_d[i];
         end
      end
   end

   assign d_out = {a_q[R], b_q[R]};

`ifdef RC5_VALID_EN
   // A 1 enters with each sampled block and reaches the top bit together with
   // that block reaching the output stage.
   logic [R:0] vld_q;
   logic [R:0] vld_d;

   always_comb begin
      vld_d = {vld_q[R-1:0], 1'b1};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) vld_q <= '0;
      else     vld_q <= vld_d;
   end

   assign d_valid = vld_q[R];
`endif

endmodule

// File: tb/tb_rc5_encoder.sv
module tb_rc5_encoder;

   logic        clk;
   logic        rst;
   logic [63:0] d_in;
   logic [63:0] d_out;
`ifdef RC5_VALID_EN
   logic        d_valid;
`endif

   int n_tests;
   int n_fail;

   logic [31:0] ms [0:25];

   rc5_encoder dut (
      .clk     (clk),
      .rst     (rst),
      .d_in    (d_in),
`ifdef RC5_VALID_EN
      .d_valid (d_valid),
`endif
      .d_out   (d_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [31:0] m_rotl(input logic [31:0] x, input int n);
      int k;
      k = n & 31;
      if (k == 0) return x;
      return (x << k) | (x >> (32 - k));
   endfunction

   task automatic build_key();
      logic [31:0] l [0:3];
      logic [31:0] a;
      logic [31:0] b;
      int i;
      int j;
      for (int k = 0; k < 4; k++) l[k] = 32'h0;
      ms[0] = 32'hB7E15163;
      for (int k = 1; k < 26; k++) ms[k] = ms[k-1] + 32'h9E3779B9;
      a = 0; b = 0; i = 0; j = 0;
      for (int k = 0; k < 78; k++) begin
         a = m_rotl(ms[i] + a + b, 3);
         ms[i] = a;
         b = m_rotl(l[j] + a + b, int'(a + b));
         l[j] = b;
         i = (i + 1) % 26;
         j = (j + 1) % 4;
      end
   endtask

   function automatic logic [63:0] enc(input logic [63:0] p);
      logic [31:0] a;
      logic [31:0] b;
      a = p[63:32] + ms[0];
      b = p[31:0] + ms[1];
      for (int i = 1; i <= 12; i++) begin
         a = m_rotl(a ^ b, int'(b[4:0])) + ms[2*i];
         b = m_rotl(b ^ a, int'(a[4:0])) + ms[2*i+1];
      end
      return {a, b};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst  = 1'b1;
      d_in = 64'h0123_4567_89AB_CDEF;
      repeat (3) tick();
      n_tests++;
      if (d_out !== 64'h0) begin
         n_fail++;
         $display("FAIL reset_dout: got %h want %h", d_out, 64'h0);
      end
`ifdef RC5_VALID_EN
      n_tests++;
      if (d_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_valid: got %b want 0", d_valid);
      end
`endif
      rst = 1'b0;
   endtask

   task automatic test_published_vector();
      d_in = 64'h0;
      repeat (14) tick();
      n_tests++;
      if (d_out !== 64'hEEDBA521_6D8F4B15) begin
         n_fail++;
         $display("FAIL published_vector: got %h want %h", d_out, 64'hEEDBA521_6D8F4B15);
      end
      n_tests++;
      if (enc(64'h0) !== 64'hEEDBA521_6D8F4B15) begin
         n_fail++;
         $display("FAIL model_vector: got %h want %h", enc(64'h0), 64'hEEDBA521_6D8F4B15);
      end
   endtask

   task automatic test_latency();
      logic [63:0] x;
      x = 64'hDEAD_BEEF_0BAD_F00D;
      rst = 1'b1;
      tick();
      d_in = x;
      rst  = 1'b0;
      for (int k = 1; k <= 13; k++) begin
         tick();
         if (k == 12) begin
            n_tests++;
            if (d_out === enc(x)) begin
               n_fail++;
               $display("FAIL latency_early: got %h before edge 13", d_out);
            end
`ifdef RC5_VALID_EN
            n_tests++;
            if (d_valid !== 1'b0) begin
               n_fail++;
               $display("FAIL latency_valid_early: got %b want 0", d_valid);
            end
`endif
         end
         if (k == 13) begin
            n_tests++;
            if (d_out !== enc(x)) begin
               n_fail++;
               $display("FAIL latency_edge13: got %h want %h", d_out, enc(x));
            end
`ifdef RC5_VALID_EN
            n_tests++;
            if (d_valid !== 1'b1) begin
               n_fail++;
               $display("FAIL latency_valid_edge13: got %b want 1", d_valid);
            end
`endif
         end
      end
   endtask

   task automatic test_streaming();
      logic [63:0] din [0:211];
      for (int k = 0; k < 212; k++) din[k] = {$urandom, $urandom};
      for (int k = 0; k < 212; k++) begin
         d_in = din[k];
         tick();
         if (k >= 12) begin
            n_tests++;
            if (d_out !== enc(din[k-12])) begin
               n_fail++;
               $display("FAIL stream[%0d]: got %h want %h", k - 12, d_out, enc(din[k-12]));
            end
         end
      end
   endtask

   task automatic test_rotate_corners();
      logic [63:0] v [0:3];
      v[0] = 64'hFFFFFFFF_FFFFFFFF;
      v[1] = 64'h80000000_00000001;
      v[2] = {32'h1234_5678, 32'h0 - ms[1]};          // first rotate amount 0
      v[3] = {32'h8765_4321, 32'd31 - ms[1]};         // first rotate amount 31
      for (int n = 0; n < 4; n++) begin
         d_in = v[n];
         repeat (13) tick();
         n_tests++;
         if (d_out !== enc(v[n])) begin
            n_fail++;
            $display("FAIL rotate[%0d]: got %h want %h", n, d_out, enc(v[n]));
         end
      end
   endtask

   task automatic test_reset_mid_stream();
      logic [63:0] din2 [0:15];
      for (int k = 0; k < 20; k++) begin
         d_in = {$urandom, $urandom};
         tick();
      end
      #2;
      rst = 1'b1;
      #1;
      n_tests++;
      if (d_out !== 64'h0) begin
         n_fail++;
         $display("FAIL async_reset_dout: got %h want %h", d_out, 64'h0);
      end
`ifdef RC5_VALID_EN
      n_tests++;
      if (d_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset_valid: got %b want 0", d_valid);
      end
`endif
      tick();
      n_tests++;
      if (d_out !== 64'h0) begin
         n_fail++;
         $display("FAIL reset_hold_dout: got %h want %h", d_out, 64'h0);
      end
      for (int k = 0; k < 16; k++) din2[k] = {$urandom, $urandom};
      rst = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         d_in = din2[k-1];
         tick();
         if (k >= 13) begin
            n_tests++;
            if (d_out !== enc(din2[k-13])) begin
               n_fail++;
               $display("FAIL resume[%0d]: got %h want %h", k - 13, d_out, enc(din2[k-13]));
            end
         end
`ifdef RC5_VALID_EN
         n_tests++;
         if (d_valid !== (k >= 13)) begin
            n_fail++;
            $display("FAIL resume_valid[%0d]: got %b want %b", k, d_valid, (k >= 13));
         end
`endif
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b1;
      d_in    = 64'h0;
      build_key();
      test_reset();
      test_published_vector();
      test_latency();
      test_streaming();
      test_rotate_corners();
      test_reset_mid_stream();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
